// File: rtl/sm4_pkg.sv
// Shared SM4 definitions: FSM states, FK constants, S-box and CK generator.
package sm4_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned KEY_W  = 128;
  localparam int unsigned NUM_RK = 32;
  localparam int unsigned CNT_W  = 5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_READY  = 2'd2
  } sm4_state_e;

  // Four-word sliding key window, k0 is the oldest word.
  typedef struct packed {
    logic [WORD_W-1:0] k0;
    logic [WORD_W-1:0] k1;
    logic [WORD_W-1:0] k2;
    logic [WORD_W-1:0] k3;
  } sm4_window_t;

  localparam logic [WORD_W-1:0] FK [4] = '{
    32'hA3B1BAC6, 32'h56AA3350, 32'h677D9197, 32'hB27022DC
  };

  localparam logic [7:0] SBOX_TABLE [256] = '{
    8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
    8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
    8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
    8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
    8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
    8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
    8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
    8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
    8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
    8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
    8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
    8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
    8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
    8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
    8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
    8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
  };

  // Byte substitution through the SM4 S-box.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TABLE[x];
  endfunction

  // Round constant: byte j of CK_i is ((4i+j)*7) mod 256, byte 0 in the MSBs.
  function automatic logic [WORD_W-1:0] ck_gen(input logic [CNT_W-1:0] i);
    logic [WORD_W-1:0] ck;
    ck = '0;
    for (int unsigned j = 0; j < 4; j++) begin
      ck[WORD_W-1-8*j -: 8] = 8'(((32'(i) << 2) + 32'(j)) * 32'd7);
    end
    return ck;
  endfunction

endpackage

// File: rtl/sm4_key_round.sv
// One SM4 key-schedule step: rk = k0 ^ L'(tau(k1 ^ k2 ^ k3 ^ ck)).
module sm4_key_round
  import sm4_pkg::*;
(
  input  logic [WORD_W-1:0] k0,
  input  logic [WORD_W-1:0] k1,
  input  logic [WORD_W-1:0] k2,
  input  logic [WORD_W-1:0] k3,
  input  logic [WORD_W-1:0] ck,
  output logic [WORD_W-1:0] rk_c
);

  logic [WORD_W-1:0] mix;
  logic [WORD_W-1:0] sub;

  // Nonlinear substitution followed by the key-schedule linear transform.
  always_comb begin
    mix  = k1 ^ k2 ^ k3 ^ ck;
    sub  = {sbox(mix[31:24]), sbox(mix[23:16]), sbox(mix[15:8]), sbox(mix[7:0])};
    rk_c = k0 ^ sub ^ {sub[18:0], sub[31:19]} ^ {sub[8:0], sub[31:9]};
  end

endmodule

// File: rtl/sm4_key_expansion.sv
// Iterative SM4 key schedule: one round key per cycle into a 32-entry array,
// presented in encryption or decryption order once ready is raised.
module sm4_key_expansion
  import sm4_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sm4_enable_in,
  input  logic              key_exp_enable_in,
  input  logic              decrypt_in,
  input  logic [KEY_W-1:0]  key_in,
  output logic              key_exp_ready_out,
  output logic [WORD_W-1:0] rk_00_out,
  output logic [WORD_W-1:0] rk_01_out,
  output logic [WORD_W-1:0] rk_02_out,
  output logic [WORD_W-1:0] rk_03_out,
  output logic [WORD_W-1:0] rk_04_out,
  output logic [WORD_W-1:0] rk_05_out,
  output logic [WORD_W-1:0] rk_06_out,
  output logic [WORD_W-1:0] rk_07_out,
  output logic [WORD_W-1:0] rk_08_out,
  output logic [WORD_W-1:0] rk_09_out,
  output logic [WORD_W-1:0] rk_10_out,
  output logic [WORD_W-1:0] rk_11_out,
  output logic [WORD_W-1:0] rk_12_out,
  output logic [WORD_W-1:0] rk_13_out,
  output logic [WORD_W-1:0] rk_14_out,
  output logic [WORD_W-1:0] rk_15_out,
  output logic [WORD_W-1:0] rk_16_out,
  output logic [WORD_W-1:0] rk_17_out,
  output logic [WORD_W-1:0] rk_18_out,
  output logic [WORD_W-1:0] rk_19_out,
  output logic [WORD_W-1:0] rk_20_out,
  output logic [WORD_W-1:0] rk_21_out,
  output logic [WORD_W-1:0] rk_22_out,
  output logic [WORD_W-1:0] rk_23_out,
  output logic [WORD_W-1:0] rk_24_out,
  output logic [WORD_W-1:0] rk_25_out,
  output logic [WORD_W-1:0] rk_26_out,
  output logic [WORD_W-1:0] rk_27_out,
  output logic [WORD_W-1:0] rk_28_out,
  output logic [WORD_W-1:0] rk_29_out,
  output logic [WORD_W-1:0] rk_30_out,
  output logic [WORD_W-1:0] rk_31_out
);

  sm4_state_e        state;
  logic [CNT_W-1:0]  cnt;
  sm4_window_t       win;
  logic [WORD_W-1:0] rk_q   [NUM_RK];
  logic [WORD_W-1:0] rk_sel [NUM_RK];
  logic              dec_q;
  logic [WORD_W-1:0] ck_c;
  logic [WORD_W-1:0] rk_new_c;
  logic              hold_c;

  assign ck_c   = ck_gen(cnt);
  // A low block enable freezes everything except the READY exit check.
  assign hold_c = !sm4_enable_in && (state == ST_IDLE || state == ST_EXPAND);

  sm4_key_round u_round (
    .k0   (win.k0),
    .k1   (win.k1),
    .k2   (win.k2),
    .k3   (win.k3),
    .ck   (ck_c),
    .rk_c (rk_new_c)
  );

  // Key-schedule FSM with window, counter, key array and ready flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state             <= ST_IDLE;
      cnt               <= '0;
      win               <= '0;
      dec_q             <= 1'b0;
      key_exp_ready_out <= 1'b0;
      for (int i = 0; i < NUM_RK; i++) begin
        rk_q[i] <= '0;
      end
    end else if (!hold_c) begin
      case (state)
        ST_IDLE: begin
          key_exp_ready_out <= 1'b0;
          if (key_exp_enable_in) begin
            win   <= key_in ^ {FK[0], FK[1], FK[2], FK[3]};
            dec_q <= decrypt_in;
            cnt   <= '0;
            state <= ST_EXPAND;
          end
        end
        ST_EXPAND: begin
          // Abort beats completion, including on the last write.
          if (!key_exp_enable_in) begin
            state <= ST_IDLE;
          end else begin
            rk_q[cnt] <= rk_new_c;
            win       <= {win.k1, win.k2, win.k3, rk_new_c};
            cnt       <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(NUM_RK - 1)) begin
              state             <= ST_READY;
              key_exp_ready_out <= 1'b1;
            end
          end
        end
        ST_READY: begin
          if (!key_exp_enable_in || !sm4_enable_in || (decrypt_in != dec_q)) begin
            state             <= ST_IDLE;
            key_exp_ready_out <= 1'b0;
          end
        end
        default: begin
          state             <= ST_IDLE;
          key_exp_ready_out <= 1'b0;
        end
      endcase
    end
  end

  // Output ordering follows the mode latched at accept time.
  always_comb begin
    for (int j = 0; j < NUM_RK; j++) begin
      rk_sel[j] = dec_q ? rk_q[CNT_W'(NUM_RK - 1 - j)] : rk_q[CNT_W'(j)];
    end
  end

  assign rk_00_out = rk_sel[0];
  assign rk_01_out = rk_sel[1];
  assign rk_02_out = rk_sel[2];
  assign rk_03_out = rk_sel[3];
  assign rk_04_out = rk_sel[4];
  assign rk_05_out = rk_sel[5];
  assign rk_06_out = rk_sel[6];
  assign rk_07_out = rk_sel[7];
  assign rk_08_out = rk_sel[8];
  assign rk_09_out = rk_sel[9];
  assign rk_10_out = rk_sel[10];
  assign rk_11_out = rk_sel[11];
  assign rk_12_out = rk_sel[12];
  assign rk_13_out = rk_sel[13];
  assign rk_14_out = rk_sel[14];
  assign rk_15_out = rk_sel[15];
  assign rk_16_out = rk_sel[16];
  assign rk_17_out = rk_sel[17];
  assign rk_18_out = rk_sel[18];
  assign rk_19_out = rk_sel[19];
  assign rk_20_out = rk_sel[20];
  assign rk_21_out = rk_sel[21];
  assign rk_22_out = rk_sel[22];
  assign rk_23_out = rk_sel[23];
  assign rk_24_out = rk_sel[24];
  assign rk_25_out = rk_sel[25];
  assign rk_26_out = rk_sel[26];
  assign rk_27_out = rk_sel[27];
  assign rk_28_out = rk_sel[28];
  assign rk_29_out = rk_sel[29];
  assign rk_30_out = rk_sel[30];
  assign rk_31_out = rk_sel[31];

endmodule

// File: tb/tb_sm4_key_expansion.sv
// Directed bench for sm4_key_expansion with an independent key-schedule model.
module tb_sm4_key_expansion;

  localparam logic [127:0] KEY_STD = 128'h0123456789ABCDEFFEDCBA9876543210;
  localparam logic [127:0] KEY_ALT = 128'h000102030405060708090A0B0C0D0E0F;

  localparam logic [31:0] FK_TB [4] = '{
    32'hA3B1BAC6, 32'h56AA3350, 32'h677D9197, 32'hB27022DC
  };

  localparam logic [7:0] SB [256] = '{
    8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
    8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
    8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
    8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
    8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
    8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
    8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
    8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
    8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
    8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
    8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
    8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
    8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
    8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
    8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
    8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
  };

  logic         clk;
  logic         reset_n;
  logic         sm4_en;
  logic         kexp_en;
  logic         dec;
  logic [127:0] key;
  logic         ready;
  logic [31:0]  rk_o [32];

  logic [31:0]  exp_rk [32];
  logic         exp_ready;
  logic         exp_dec;
  logic         mon_on;
  int           n_checks;
  int           n_fail;

  sm4_key_expansion dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .sm4_enable_in     (sm4_en),
    .key_exp_enable_in (kexp_en),
    .decrypt_in        (dec),
    .key_in            (key),
    .key_exp_ready_out (ready),
    .rk_00_out (rk_o[0]),  .rk_01_out (rk_o[1]),  .rk_02_out (rk_o[2]),  .rk_03_out (rk_o[3]),
    .rk_04_out (rk_o[4]),  .rk_05_out (rk_o[5]),  .rk_06_out (rk_o[6]),  .rk_07_out (rk_o[7]),
    .rk_08_out (rk_o[8]),  .rk_09_out (rk_o[9]),  .rk_10_out (rk_o[10]), .rk_11_out (rk_o[11]),
    .rk_12_out (rk_o[12]), .rk_13_out (rk_o[13]), .rk_14_out (rk_o[14]), .rk_15_out (rk_o[15]),
    .rk_16_out (rk_o[16]), .rk_17_out (rk_o[17]), .rk_18_out (rk_o[18]), .rk_19_out (rk_o[19]),
    .rk_20_out (rk_o[20]), .rk_21_out (rk_o[21]), .rk_22_out (rk_o[22]), .rk_23_out (rk_o[23]),
    .rk_24_out (rk_o[24]), .rk_25_out (rk_o[25]), .rk_26_out (rk_o[26]), .rk_27_out (rk_o[27]),
    .rk_28_out (rk_o[28]), .rk_29_out (rk_o[29]), .rk_30_out (rk_o[30]), .rk_31_out (rk_o[31])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] ck_tb(input int i);
    logic [31:0] c;
    c = 32'd0;
    for (int j = 0; j < 4; j++) begin
      c = (c << 8) | 32'(((4 * i + j) * 7) % 256);
    end
    return c;
  endfunction

  // Full key schedule from the master key into exp_rk[0..31].
  task automatic model_keys(input logic [127:0] mk);
    logic [31:0] k [36];
    logic [31:0] t;
    logic [31:0] s;
    for (int i = 0; i < 4; i++) begin
      k[i] = mk[127 - 32 * i -: 32] ^ FK_TB[i];
    end
    for (int i = 0; i < 32; i++) begin
      t = k[i + 1] ^ k[i + 2] ^ k[i + 3] ^ ck_tb(i);
      for (int j = 0; j < 4; j++) begin
        s[31 - 8 * j -: 8] = SB[t[31 - 8 * j -: 8]];
      end
      k[i + 4]  = k[i] ^ s ^ rotl(s, 13) ^ rotl(s, 23);
      exp_rk[i] = k[i + 4];
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string name);
    logic [31:0] acc;
    acc = 32'd0;
    for (int j = 0; j < 32; j++) acc = acc | rk_o[j];
    check(name, {31'd0, ready} | acc, 32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept edge, then `total` cycles with an optional enable stall; ready expected on the last.
  task automatic expand(input int total, input int stall_at, input int stall_len);
    sm4_en = 1'b1;
    tick();
    for (int i = 1; i <= total; i++) begin
      sm4_en = (i > stall_at && i <= stall_at + stall_len) ? 1'b0 : 1'b1;
      tick();
      exp_ready = (i == total);
    end
    check("ready_latency", {31'd0, ready}, 32'd1);
  endtask

  // Per-cycle compare: ready always, and the full ordered key set while ready.
  always @(negedge clk) begin
    if (mon_on) begin
      check("ready", {31'd0, ready}, {31'd0, exp_ready});
      if (exp_ready) begin
        int bad;
        logic [31:0] want;
        bad = 0;
        for (int j = 0; j < 32; j++) begin
          want = exp_dec ? exp_rk[31 - j] : exp_rk[j];
          if (rk_o[j] !== want) begin
            bad++;
            $display("FAIL rk_%0d: got %h expected %h at %0t", j, rk_o[j], want, $time);
          end
        end
        n_checks++;
        if (bad != 0) n_fail++;
      end
    end
  end

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    mon_on    = 1'b0;
    exp_ready = 1'b0;
    exp_dec   = 1'b0;
    reset_n   = 1'b0;
    sm4_en    = 1'b0;
    kexp_en   = 1'b0;
    dec       = 1'b0;
    key       = '0;

    // Model anchored to the published SM4 round keys.
    model_keys(KEY_STD);
    check("model_rk0", exp_rk[0], 32'hF12186F9);
    check("model_rk1", exp_rk[1], 32'h41662B61);
    check("model_rk31", exp_rk[31], 32'h9124A012);

    #3;
    check_all_zero("reset_state");
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset_after_edges");
    reset_n = 1'b1;
    mon_on  = 1'b1;

    // Standard vector, encryption order.
    key = KEY_STD; dec = 1'b0; kexp_en = 1'b1; exp_dec = 1'b0;
    expand(32, 0, 0);
    check("enc_rk00", rk_o[0], 32'hF12186F9);
    check("enc_rk01", rk_o[1], 32'h41662B61);
    check("enc_rk31", rk_o[31], 32'h9124A012);
    repeat (3) tick();

    // Mode change leaves READY, then re-expands in decryption order.
    dec = 1'b1;
    tick();
    exp_ready = 1'b0;
    exp_dec   = 1'b1;
    expand(32, 0, 0);
    check("dec_rk00", rk_o[0], 32'h9124A012);
    check("dec_rk31", rk_o[31], 32'hF12186F9);

    // Abort at cnt=10 with a different key, then a clean standard request.
    kexp_en = 1'b0;
    tick();
    exp_ready = 1'b0;
    dec = 1'b0; key = KEY_ALT; kexp_en = 1'b1;
    tick();
    repeat (10) tick();
    kexp_en = 1'b0;
    tick();
    check("abort_ready", {31'd0, ready}, 32'd0);
    repeat (5) tick();
    key = KEY_STD; kexp_en = 1'b1; exp_dec = 1'b0;
    expand(32, 0, 0);
    check("post_abort_rk00", rk_o[0], 32'hF12186F9);

    // Abort on the edge that would write the last key.
    kexp_en = 1'b0;
    tick();
    exp_ready = 1'b0;
    kexp_en = 1'b1;
    tick();
    repeat (31) tick();
    kexp_en = 1'b0;
    tick();
    check("late_abort_ready", {31'd0, ready}, 32'd0);
    repeat (3) tick();
    kexp_en = 1'b1;
    expand(32, 0, 0);

    // Block enable low exits READY and freezes IDLE; then a 5-cycle stall mid-expansion.
    sm4_en = 1'b0;
    tick();
    exp_ready = 1'b0;
    repeat (2) tick();
    expand(37, 10, 5);

    // Asynchronous reset at cnt=20.
    kexp_en = 1'b0;
    tick();
    exp_ready = 1'b0;
    kexp_en = 1'b1;
    tick();
    repeat (20) tick();
    reset_n = 1'b0;
    #1;
    check_all_zero("reset_mid_expand");
    tick();
    reset_n = 1'b1;
    expand(32, 0, 0);

    // Asynchronous reset while READY.
    reset_n   = 1'b0;
    exp_ready = 1'b0;
    #1;
    check_all_zero("reset_in_ready");
    tick();
    reset_n = 1'b1;
    expand(32, 0, 0);

    // Re-key: new key ignored in READY, used after a re-request.
    key = KEY_ALT;
    repeat (3) tick();
    check("rekey_hold_rk00", rk_o[0], 32'hF12186F9);
    kexp_en = 1'b0;
    tick();
    exp_ready = 1'b0;
    model_keys(KEY_ALT);
    kexp_en = 1'b1;
    expand(32, 0, 0);
    repeat (2) tick();

    mon_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
